fp_result_buffer: RTL and testbench

Downstream consumer of the FP multiplier wrapper's output handshake. Accepts IEEE-754 single-precision products on a valid/ready interface and buffers them in a small FIFO. Tags each entry with a 3-bit class code (normal/zero/denormal/Inf/NaN) and re-presents entries on a valid/ready output toward the checker or scoreboard. Lets the multiplier stage keep issuing while the sink stalls, and optionally keeps per-class event counters.

---
 rtl/fp_result_buffer.sv | 145 ++++++++++++++
 tb/tb_fp_result_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_buffer.sv
// Result FIFO for IEEE-754 single-precision products; tags each entry with its class.
// Optional per-class event counters are built when FP_CLASS_COUNT_EN is defined.
module fp_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     flush,
    input  logic                     clear_cnt,
    output logic [CNT_W-1:0]         cnt_zero,
    output logic [CNT_W-1:0]         cnt_denorm,
    output logic [CNT_W-1:0]         cnt_inf,
    output logic [CNT_W-1:0]         cnt_nan
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] CLS_NORMAL = 3'd0;
    localparam logic [2:0] CLS_ZERO   = 3'd1;
    localparam logic [2:0] CLS_DENORM = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [2:0] classify(input logic [31:0] d);
        logic [2:0] c;
        c = CLS_NORMAL;
        if (d[30:23] == 8'hFF)
            c = (d[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (d[30:23] == 8'h00)
            c = (d[22:0] != 23'd0) ? CLS_DENORM : CLS_ZERO;
        return c;
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [LW-1:0]   r_level;
    logic [34:0]     r_mem [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_in_class;
    logic [34:0]     w_head;

    assign w_in_class = classify(in_data);
    assign in_ready   = (r_state == ST_RUN) && (r_level != LW'(DEPTH)) && !flush;
    assign out_valid  = (r_level != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign level      = r_level;

    // Storage is never reset; the empty-gating below keeps stale words off the outputs.
    assign w_head    = r_mem[r_rd];
    assign out_data  = out_valid ? w_head[31:0]  : 32'd0;
    assign out_class = out_valid ? w_head[34:32] : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_in_class, in_data};
    end

`ifdef FP_CLASS_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] r_cnt_zero;
    logic [CNT_W-1:0] r_cnt_denorm;
    logic [CNT_W-1:0] r_cnt_inf;
    logic [CNT_W-1:0] r_cnt_nan;

    // Normal-class pushes are deliberately not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear_cnt) begin
            r_cnt_zero   <= '0;
            r_cnt_denorm <= '0;
            r_cnt_inf    <= '0;
            r_cnt_nan    <= '0;
        end else if (w_push) begin
            case (w_in_class)
                CLS_ZERO:   r_cnt_zero   <= sat_inc(r_cnt_zero);
                CLS_DENORM: r_cnt_denorm <= sat_inc(r_cnt_denorm);
                CLS_INF:    r_cnt_inf    <= sat_inc(r_cnt_inf);
                CLS_NAN:    r_cnt_nan    <= sat_inc(r_cnt_nan);
                default:    ;
            endcase
        end
    end

    assign cnt_zero   = r_cnt_zero;
    assign cnt_denorm = r_cnt_denorm;
    assign cnt_inf    = r_cnt_inf;
    assign cnt_nan    = r_cnt_nan;
`else
    logic w_unused_clear;
    assign w_unused_clear = clear_cnt;
    assign cnt_zero   = '0;
    assign cnt_denorm = '0;
    assign cnt_inf    = '0;
    assign cnt_nan    = '0;
`endif

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed bench for fp_result_buffer: class table, fill/drain, wrap, flush, saturation, async reset.
module tb_fp_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FP_CLASS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [2:0]       out_class;
    logic [LW-1:0]    level;
    logic             flush;
    logic             clear_cnt;
    logic [CNT_W-1:0] cnt_zero;
    logic [CNT_W-1:0] cnt_denorm;
    logic [CNT_W-1:0] cnt_inf;
    logic [CNT_W-1:0] cnt_nan;

    int n_checks = 0;
    int n_errors = 0;

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_class(out_class),
        .level(level), .flush(flush), .clear_cnt(clear_cnt),
        .cnt_zero(cnt_zero), .cnt_denorm(cnt_denorm),
        .cnt_inf(cnt_inf), .cnt_nan(cnt_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cls;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic clear_counters;
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
    endtask

    int exp_cnt [5];
    logic [31:0] q [$];
    logic [31:0] nxt;
    logic [31:0] exp_head;
    logic        did_push;
    logic        did_pop;

    initial begin
        vecs[0]  = '{32'h3F800000, 3'd0};
        vecs[1]  = '{32'h00000000, 3'd1};
        vecs[2]  = '{32'h80000000, 3'd1};
        vecs[3]  = '{32'h00000001, 3'd2};
        vecs[4]  = '{32'h807FFFFF, 3'd2};
        vecs[5]  = '{32'h7F800000, 3'd3};
        vecs[6]  = '{32'hFF800000, 3'd3};
        vecs[7]  = '{32'h7FC00000, 3'd4};
        vecs[8]  = '{32'hFF800001, 3'd4};
        vecs[9]  = '{32'h00800000, 3'd0};
        vecs[10] = '{32'h7F7FFFFF, 3'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; clear_cnt = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_cnt_zero", 32'(cnt_zero), 32'd0);
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("init_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("run_in_ready_high", 32'(in_ready), 32'd1);

        // class table: push one, see it the next cycle, pop it
        foreach (exp_cnt[k]) exp_cnt[k] = 0;
        for (int i = 0; i < 11; i++) begin
            push1(vecs[i].data);
            exp_cnt[vecs[i].cls]++;
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_out_data", out_data, vecs[i].data);
            check("tbl_out_class", 32'(out_class), 32'(vecs[i].cls));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("tbl_level_after_pop", 32'(level), 32'd0);
        end
        check("tbl_cnt_zero", 32'(cnt_zero), CNT_EN ? 32'(exp_cnt[1]) : 32'd0);
        check("tbl_cnt_denorm", 32'(cnt_denorm), CNT_EN ? 32'(exp_cnt[2]) : 32'd0);
        check("tbl_cnt_inf", 32'(cnt_inf), CNT_EN ? 32'(exp_cnt[3]) : 32'd0);
        check("tbl_cnt_nan", 32'(cnt_nan), CNT_EN ? 32'(exp_cnt[4]) : 32'd0);

        // fill to full with one of each special class
        clear_counters();
        push1(32'h00000000);
        push1(32'h80000001);
        push1(32'hFF800000);
        push1(32'h7FC00000);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        check("full_cnt_zero", 32'(cnt_zero), CNT_EN ? 32'd1 : 32'd0);
        check("full_cnt_denorm", 32'(cnt_denorm), CNT_EN ? 32'd1 : 32'd0);
        check("full_cnt_inf", 32'(cnt_inf), CNT_EN ? 32'd1 : 32'd0);
        check("full_cnt_nan", 32'(cnt_nan), CNT_EN ? 32'd1 : 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_class", 32'(out_class), 32'(k));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // wrap: start full, stream for 10 cycles, then drain and check order
        q.delete();
        for (int k = 0; k < 4; k++) begin
            push1(32'h40000000 + 32'(k));
            q.push_back(32'h40000000 + 32'(k));
        end
        nxt = 32'h40000004;
        for (int c = 0; c < 10; c++) begin
            in_valid  = 1'b1;
            in_data   = nxt;
            out_ready = 1'b1;
            if (level == LW'(4)) check("wrap_ready_when_full", 32'(in_ready), 32'd0);
            did_push = in_ready;
            did_pop  = out_valid;
            if (did_pop) begin
                exp_head = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
                check("wrap_order", out_data, exp_head);
            end
            if (did_push) begin
                q.push_back(nxt);
                nxt = nxt + 32'd1;
            end
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8 && out_valid; c++) begin
            exp_head = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
            check("wrap_drain_order", out_data, exp_head);
            step();
        end
        out_ready = 1'b0;
        check("wrap_none_lost", 32'(q.size()), 32'd0);
        check("wrap_empty", 32'(level), 32'd0);

        // concurrent push+pop at level 2, then flush with a push attempt
        push1(32'h11111111);
        push1(32'h22222222);
        in_valid = 1'b1; in_data = 32'h33333333; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_level", 32'(level), 32'd2);
        check("pp_head", out_data, 32'h22222222);
        in_valid = 1'b1; in_data = 32'h44444444; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        push1(32'h55555555);
        check("post_flush_head", out_data, 32'h55555555);
        check("post_flush_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // counter saturation and clear priority
        clear_counters();
        in_valid = 1'b1; in_data = 32'h00000000; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) step();
        check("sat_cnt_zero", 32'(cnt_zero), CNT_EN ? 32'd15 : 32'd0);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0; in_valid = 1'b0;
        check("clear_over_inc", 32'(cnt_zero), 32'd0);
        step();
        out_ready = 1'b0;
        check("sat_drained", 32'(level), 32'd0);

        // asynchronous reset mid-cycle with three entries held
        push1(32'h3F800000);
        push1(32'h00000000);
        push1(32'h7F800000);
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_cnt_inf", 32'(cnt_inf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rearm_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("rearm_in_ready_high", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
